// File: rtl/x_tdc_edge_capture.sv
// rtl/x_tdc_edge_capture.sv - arms on request, bubble-corrects delay-line snapshots, captures first hit as fine/coarse timestamp
//
// Ports:
//   i_clk      clock (delay-line mux domain)
//   i_rst      asynchronous active-high reset
//   i_data     WIDTH-bit tap snapshot, one new word per cycle
//   i_arm      single-cycle arm request, honoured only while idle
//   i_ready    readout accepts the held result
//   o_valid    result held (HOLD state)
//   o_fine     corrected ones count of the captured snapshot
//   o_coarse   cycles since arm at which the captured snapshot was sampled
//   o_timeout  one-cycle pulse when the coarse counter wraps with no event
//   o_busy     block is not idle

module x_tdc_edge_capture #(
    parameter int WIDTH    = 32,
    parameter int COARSE_W = 16,
    parameter int FINE_W   = $clog2(WIDTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [WIDTH-1:0]    i_data,
    input  logic                i_arm,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [FINE_W-1:0]   o_fine,
    output logic [COARSE_W-1:0] o_coarse,
    output logic                o_timeout,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [COARSE_W-1:0] cnt;

    // S1: raw snapshot plus the arm tag and coarse count it was sampled under
    logic [WIDTH-1:0]    s1_data;
    logic                s1_tag;
    logic [COARSE_W-1:0] s1_cnt;

    // S2: corrected popcount with the same tag and count carried along
    logic [FINE_W-1:0]   s2_pop;
    logic                s2_tag;
    logic [COARSE_W-1:0] s2_cnt;

    logic [WIDTH-1:0]    corr;
    logic [FINE_W-1:0]   pop;
    logic                hit;
    logic                wrap;

    // Three-of-neighbourhood majority removes single-tap bubbles; the end
    // taps have only one neighbour and pass straight through.
    always_comb begin
        corr = s1_data;
        for (int k = 1; k < WIDTH - 1; k++) begin
            corr[k] = (s1_data[k-1] & s1_data[k])
                    | (s1_data[k-1] & s1_data[k+1])
                    | (s1_data[k]   & s1_data[k+1]);
        end
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < WIDTH; k++) begin
            pop = pop + FINE_W'(corr[k]);
        end
    end

    // The state check keeps words still in flight after a capture or a
    // timeout from qualifying; the tag rejects words sampled before arm.
    assign hit  = (state == S_ARMED) && s2_tag && (s2_pop != '0);
    assign wrap = &cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_arm) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                // An event on the wrap cycle takes priority over the timeout.
                if (hit) begin
                    state_nxt = S_HOLD;
                end else if (wrap) begin
                    state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (i_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_valid   = (state == S_HOLD);
        o_busy    = (state != S_IDLE);
        o_timeout = (state == S_ARMED) && wrap && !hit;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (state == S_IDLE && i_arm) begin
            cnt <= '0;
        end else if (state == S_ARMED) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_data <= '0;
            s1_tag  <= 1'b0;
            s1_cnt  <= '0;
            s2_pop  <= '0;
            s2_tag  <= 1'b0;
            s2_cnt  <= '0;
        end else begin
            s1_data <= i_data;
            s1_tag  <= (state == S_ARMED);
            s1_cnt  <= cnt;
            s2_pop  <= pop;
            s2_tag  <= s1_tag;
            s2_cnt  <= s1_cnt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_fine   <= '0;
            o_coarse <= '0;
        end else if (hit) begin
            o_fine   <= s2_pop;
            o_coarse <= s2_cnt;
        end
    end

endmodule

// File: tb/tb_x_tdc_edge_capture.sv
// tb/tb_x_tdc_edge_capture.sv - randomized self-checking bench for x_tdc_edge_capture

module tb_x_tdc_edge_capture;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        arm;
    logic        arm4;
    logic        ready;

    logic        valid, timeout, busy;
    logic [5:0]  fine;
    logic [15:0] coarse;

    logic        valid4, timeout4, busy4;
    logic [5:0]  fine4;
    logic [3:0]  coarse4;

    int n_checks = 0;
    int n_fail   = 0;

    x_tdc_edge_capture dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_arm     (arm),
        .i_ready   (ready),
        .o_valid   (valid),
        .o_fine    (fine),
        .o_coarse  (coarse),
        .o_timeout (timeout),
        .o_busy    (busy)
    );

    x_tdc_edge_capture #(.WIDTH(32), .COARSE_W(4)) dut4 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_arm     (arm4),
        .i_ready   (ready),
        .o_valid   (valid4),
        .o_fine    (fine4),
        .o_coarse  (coarse4),
        .o_timeout (timeout4),
        .o_busy    (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: majority-of-three over neighbouring taps, end taps kept.
    function automatic int corr_pop(input logic [31:0] w);
        int n;
        int s;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 0 || i == 31) begin
                n += int'(w[i]);
            end else begin
                s = int'(w[i-1]) + int'(w[i]) + int'(w[i+1]);
                if (s >= 2) n++;
            end
        end
        return n;
    endfunction

    // Arm the 16-bit instance, present nz zero words, then ev, then all-ones
    // (so a capture always happens). Hold the result for `hold` cycles.
    task automatic run_txn(input logic [31:0] pre, input int nz, input logic [31:0] ev,
                           input int hold, input bit exit_arm, input string name);
        logic [31:0] snaps[$];
        int kc;
        int j;
        int exp_fine;
        for (int i = 0; i < nz; i++) snaps.push_back(32'h0);
        snaps.push_back(ev);
        snaps.push_back(32'hFFFF_FFFF);
        kc = -1;
        for (int i = 0; i < snaps.size(); i++) begin
            if (kc < 0 && corr_pop(snaps[i]) != 0) kc = i;
        end
        exp_fine = corr_pop(snaps[kc]);

        data  = pre;
        arm   = 1'b1;
        ready = 1'($urandom_range(0, 1));
        tick();
        arm = 1'b0;
        check({name, "/busy_arm"}, busy, 1);
        check({name, "/valid_arm"}, valid, 0);

        // Snapshot index kc is sampled at arm+1+kc; valid rises two edges later.
        j = 0;
        while (j < kc + 3) begin
            data  = (j < snaps.size()) ? snaps[j] : $urandom;
            ready = 1'($urandom_range(0, 1));
            arm   = 1'($urandom_range(0, 1));
            tick();
            j++;
            if (j < kc + 3) begin
                check({name, "/valid_early"}, valid, 0);
                check({name, "/busy_armed"}, busy, 1);
            end
            check({name, "/timeout"}, timeout, 0);
        end
        arm = 1'b0;
        check({name, "/valid"}, valid, 1);
        check({name, "/fine"}, fine, exp_fine);
        check({name, "/coarse"}, coarse, kc);

        for (int h = 0; h < hold; h++) begin
            data  = $urandom;
            ready = 1'b0;
            arm   = 1'($urandom_range(0, 1));
            tick();
            check({name, "/hold_valid"}, valid, 1);
            check({name, "/hold_fine"}, fine, exp_fine);
            check({name, "/hold_coarse"}, coarse, kc);
        end

        ready = 1'b1;
        arm   = exit_arm;
        data  = $urandom;
        tick();
        check({name, "/valid_drop"}, valid, 0);
        check({name, "/busy_drop"}, busy, 0);
        ready = 1'b0;
        arm   = 1'b0;
        tick();
        check({name, "/no_rearm"}, busy, 0);
    endtask

    // Small-counter instance: only snapshot k is non-zero (k >= 32 means none).
    task automatic run_small(input int k, input string name);
        bit cap;
        bit vexp, texp, bexp;
        cap   = (k <= 13);
        ready = 1'b0;
        data  = 32'h0;
        arm4  = 1'b1;
        tick();
        arm4 = 1'b0;
        check({name, "/busy_arm"}, busy4, 1);
        check({name, "/timeout_arm"}, timeout4, 0);
        for (int j = 1; j <= 20; j++) begin
            data = (j - 1 == k) ? 32'hFFFF_FFFF : 32'h0;
            tick();
            vexp = cap && (j >= k + 3);
            texp = !cap && (j == 15);
            bexp = cap ? 1'b1 : (j < 16);
            check($sformatf("%s/valid_j%0d", name, j), valid4, vexp);
            check($sformatf("%s/timeout_j%0d", name, j), timeout4, texp);
            check($sformatf("%s/busy_j%0d", name, j), busy4, bexp);
            if (vexp) begin
                check($sformatf("%s/coarse_j%0d", name, j), coarse4, k);
                check($sformatf("%s/fine_j%0d", name, j), fine4, 32);
            end
        end
        data  = 32'h0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check({name, "/valid_end"}, valid4, 0);
        check({name, "/busy_end"}, busy4, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ev;
        rst   = 1'b1;
        data  = 32'h0;
        arm   = 1'b0;
        arm4  = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        check("rst/valid", valid, 0);
        check("rst/fine", fine, 0);
        check("rst/coarse", coarse, 0);
        check("rst/timeout", timeout, 0);
        check("rst/busy", busy, 0);
        check("rst/busy4", busy4, 0);
        rst = 1'b0;
        tick();

        // Directed cases
        run_txn(32'h0, 5, 32'h0000_FFFF, 0, 1'b0, "five_zero");
        run_txn(32'h0, 0, 32'h0000_FEFF, 2, 1'b1, "bubble");
        run_txn(32'h0, 0, 32'hCCCC_CCCC, 1, 1'b0, "pairs");
        run_txn(32'h0, 2, 32'h2222_2222, 0, 1'b0, "isolated");
        run_txn(32'h0, 1, 32'hFFFF_FFFF, 10, 1'b1, "hold10");

        // Non-zero words before arm must never be captured
        data = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("prearm/busy", busy, 0);
            check("prearm/valid", valid, 0);
        end
        run_txn(32'hFFFF_FFFF, 4, 32'h0000_00F0, 0, 1'b0, "prearm");

        // Timeout and event-versus-wrap boundary on the 4-bit counter
        run_small(99, "tmo_none");
        run_small(14, "tmo_k14");
        run_small(13, "evt_k13");
        run_small(3,  "evt_k3");

        // Asynchronous reset while holding a result
        data = 32'h0;
        arm  = 1'b1;
        tick();
        arm  = 1'b0;
        data = 32'hFFFF_FFFF;
        tick();
        data = 32'h0;
        tick();
        tick();
        check("rstmid/valid_before", valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid/valid", valid, 0);
        check("rstmid/fine", fine, 0);
        check("rstmid/coarse", coarse, 0);
        check("rstmid/busy", busy, 0);
        check("rstmid/timeout", timeout, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rstmid/idle", busy, 0);
        run_txn(32'h0, 3, 32'h0F0F_0000, 1, 1'b0, "after_rst");

        // Randomized transactions
        for (int r = 0; r < 25; r++) begin
            case ($urandom_range(0, 2))
                0:       ev = $urandom;
                1:       ev = $urandom & $urandom & $urandom;
                default: ev = $urandom & $urandom & $urandom & $urandom & $urandom;
            endcase
            run_txn($urandom, $urandom_range(0, 8), ev, $urandom_range(0, 5),
                    1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
